// File: rtl/branch_predictor_gshare.sv
// gshare conditional-branch predictor.
// A table of CTR_W-bit saturating counters is indexed by PC XOR a speculative global
// history register (GHR). On a mispredict the GHR is rebuilt from the resolved branch's
// history snapshot, and a registered flush/redirect is issued in the following cycle.
// Optional build macro: PRED_STATS_EN adds saturating update/mispredict counters.
module branch_predictor_gshare #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned GHR_W  = 4,
  parameter int unsigned CTR_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  // Lookup port (fetch)
  input  logic              lk_valid,
  input  logic              lk_is_branch,
  input  logic [ADDR_W-1:0] lk_pc,
  input  logic [7:0]        lk_offset,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] predict_dst,
  output logic [GHR_W-1:0]  lookup_ghr,
  // Resolution port (execute)
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_target,
  // Redirect
  output logic              flush_valid,
  output logic [ADDR_W-1:0] flush_dst
`ifdef PRED_STATS_EN
  ,
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispredicts
`endif
);

  localparam int unsigned Depth = 1 << IDX_W;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0] CtrInit = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CtrMax  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CtrMin  = {CTR_W{1'b0}};

  // Shift one outcome into the youngest history position; valid for any GHR_W >= 1.
  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] g, input logic b);
    logic [GHR_W-1:0] r;
    r[0] = b;
    for (int i = 1; i < GHR_W; i++) begin
      r[i] = g[i-1];
    end
    return r;
  endfunction

  // State
  logic [CTR_W-1:0]  ctr_q [Depth];
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic              flush_valid_q, flush_valid_d;
  logic [ADDR_W-1:0] flush_dst_q, flush_dst_d;

  // Lookup-side signals
  logic [IDX_W-1:0]  lk_idx;
  logic              lk_ctr_msb;
  logic [ADDR_W-1:0] lk_fall;
  logic [ADDR_W-1:0] lk_offset_ext;
  logic              lk_shift;

  // Update-side signals
  logic [IDX_W-1:0]  upd_idx;
  logic [CTR_W-1:0]  upd_ctr;
  logic [CTR_W-1:0]  upd_ctr_nx;
  logic              mispredict;

  // Lookup: table read is combinational and sees the pre-update counter.
  always_comb begin
    lk_idx        = lk_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);
    lk_ctr_msb    = ctr_q[lk_idx][CTR_W-1];
    predict_taken = lk_valid & lk_is_branch & lk_ctr_msb;
    lk_fall       = lk_pc + ADDR_W'(1);
    lk_offset_ext = ADDR_W'($signed(lk_offset));
    predict_dst   = predict_taken ? (lk_fall + lk_offset_ext) : lk_fall;
    lookup_ghr    = ghr_q;
    lk_shift      = enable & lk_valid & lk_is_branch;
  end

  // Resolution: pick the trained counter and compute its saturated next value.
  always_comb begin
    upd_idx    = upd_pc[IDX_W-1:0] ^ IDX_W'(upd_ghr);
    upd_ctr    = ctr_q[upd_idx];
    upd_ctr_nx = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CtrMax) upd_ctr_nx = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != CtrMin) upd_ctr_nx = upd_ctr - CTR_W'(1);
    end
    mispredict = upd_valid & (upd_taken ^ upd_pred_taken);
  end

  // GHR next state: recovery wins over a same-cycle speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict) begin
      ghr_d = ghr_shift(upd_ghr, upd_taken);
    end else if (lk_shift) begin
      ghr_d = ghr_shift(ghr_q, predict_taken);
    end
  end

  // Redirect next state: fall-through on a not-taken mispredict, target otherwise.
  always_comb begin
    flush_valid_d = mispredict;
    flush_dst_d   = flush_dst_q;
    if (mispredict) begin
      flush_dst_d = upd_taken ? upd_target : (upd_pc + ADDR_W'(1));
    end
  end

  // Counter table: whole table re-initialised by a single reset cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        ctr_q[i] <= CtrInit;
      end
    end else if (upd_valid) begin
      ctr_q[upd_idx] <= upd_ctr_nx;
    end
  end

  // GHR and redirect registers; reset also drops a pending flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      ghr_q         <= '0;
      flush_valid_q <= 1'b0;
      flush_dst_q   <= '0;
    end else begin
      ghr_q         <= ghr_d;
      flush_valid_q <= flush_valid_d;
      flush_dst_q   <= flush_dst_d;
    end
  end

  assign flush_valid = flush_valid_q;
  assign flush_dst   = flush_dst_q;

`ifdef PRED_STATS_EN
  logic [15:0] stat_br_q, stat_br_d;
  logic [15:0] stat_mp_q, stat_mp_d;

  // Statistics next state: saturating at all-ones.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_valid && (stat_br_q != 16'hFFFF)) stat_br_d = stat_br_q + 16'd1;
    if (mispredict && (stat_mp_q != 16'hFFFF)) stat_mp_d = stat_mp_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench for branch_predictor_gshare: stimulus pushes expectations, a negedge
// monitor pops and compares them against the DUT.
module tb_branch_predictor_gshare;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        lk_valid, lk_is_branch;
  logic [11:0] lk_pc;
  logic [7:0]  lk_offset;
  logic        predict_taken;
  logic [11:0] predict_dst;
  logic [3:0]  lookup_ghr;
  logic        upd_valid;
  logic [11:0] upd_pc;
  logic [3:0]  upd_ghr;
  logic        upd_taken, upd_pred_taken;
  logic [11:0] upd_target;
  logic        flush_valid;
  logic [11:0] flush_dst;
`ifdef PRED_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor_gshare dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .lk_valid       (lk_valid),
    .lk_is_branch   (lk_is_branch),
    .lk_pc          (lk_pc),
    .lk_offset      (lk_offset),
    .predict_taken  (predict_taken),
    .predict_dst    (predict_dst),
    .lookup_ghr     (lookup_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_ghr        (upd_ghr),
    .upd_taken      (upd_taken),
    .upd_pred_taken (upd_pred_taken),
    .upd_target     (upd_target),
    .flush_valid    (flush_valid),
    .flush_dst      (flush_dst)
`ifdef PRED_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [11:0] dst;
  } fl_t;

  localparam int KPt = 0, KDst = 1, KGhr = 2, KFdst = 3, KStB = 4, KStM = 5;

  exp_t exp_q[$];
  fl_t  fl_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: flush_valid checked every cycle, other expectations when their cycle comes.
  always @(negedge clock) begin
    logic        exp_fv;
    logic [31:0] act;
    exp_t        e;
    exp_fv = (fl_q.size() > 0) && (fl_q[0].cyc == cyc);
    n_checks++;
    if (flush_valid !== exp_fv) begin
      n_fail++;
      $display("FAIL flush_valid cyc %0d: got %b want %b", cyc, flush_valid, exp_fv);
    end
    if (exp_fv) begin
      n_checks++;
      if (flush_dst !== fl_q[0].dst) begin
        n_fail++;
        $display("FAIL flush_dst cyc %0d: got %h want %h", cyc, flush_dst, fl_q[0].dst);
      end
      void'(fl_q.pop_front());
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e   = exp_q.pop_front();
      act = '0;
      case (e.kind)
        KPt:   act = {31'd0, predict_taken};
        KDst:  act = {20'd0, predict_dst};
        KGhr:  act = {28'd0, lookup_ghr};
        KFdst: act = {20'd0, flush_dst};
`ifdef PRED_STATS_EN
        KStB:  act = {16'd0, stat_branches};
        KStM:  act = {16'd0, stat_mispredicts};
`endif
        default: act = '0;
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %h want %h", e.name, cyc, act, e.val);
      end
    end
  end

  task automatic clr();
    enable = 1'b1; lk_valid = 1'b0; lk_is_branch = 1'b0; lk_pc = '0; lk_offset = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
    upd_pred_taken = 1'b0; upd_target = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clr();
  endtask

  task automatic want(input int kind, input logic [31:0] val, input string name);
    exp_q.push_back('{cyc, kind, val, name});
  endtask

  task automatic lk(input logic [11:0] pc, input logic [7:0] off, input logic en,
                    input logic br);
    lk_valid = 1'b1; lk_is_branch = br; lk_pc = pc; lk_offset = off; enable = en;
  endtask

  task automatic lk_want(input logic pt, input logic [11:0] dst, input logic [3:0] g,
                         input string tag);
    want(KPt, {31'd0, pt}, {tag, "_taken"});
    want(KDst, {20'd0, dst}, {tag, "_dst"});
    want(KGhr, {28'd0, g}, {tag, "_ghr"});
  endtask

  task automatic upd(input logic [11:0] pc, input logic [3:0] g, input logic t,
                     input logic p, input logic [11:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = t;
    upd_pred_taken = p; upd_target = tgt;
    if ((t != p) && !reset) fl_q.push_back('{cyc + 1, t ? tgt : pc + 12'd1});
  endtask

  initial begin
    reset = 1'b1;
    clr();
    tick();
    tick();
    reset = 1'b0;
    // Reset state and first lookup; counters weakly not-taken.
    lk(12'h010, 8'h05, 1'b1, 1'b1);
    lk_want(1'b0, 12'h011, 4'h0, "rst_lookup");
    want(KFdst, 32'h0, "rst_flush_dst");
    tick();
    // Train counter 0 up twice: 01 -> 10 -> 11.
    upd(12'h010, 4'h0, 1'b1, 1'b1, 12'h000);
    tick();
    upd(12'h010, 4'h0, 1'b1, 1'b1, 12'h000);
    tick();
    lk(12'h010, 8'h05, 1'b1, 1'b1);
    lk_want(1'b1, 12'h016, 4'h0, "trained");
    tick();
    // Saturate at 11, then one not-taken mispredict -> 10, ghr recovered to 0.
    upd(12'h010, 4'h0, 1'b1, 1'b1, 12'h000);
    tick();
    upd(12'h010, 4'h0, 1'b0, 1'b1, 12'h000);
    want(KGhr, 32'h1, "spec_shift_ghr");
    tick();
    lk(12'h010, 8'h05, 1'b1, 1'b1);
    lk_want(1'b1, 12'h016, 4'h0, "after_sat");
    tick();
    // Recovery overrides the same-cycle shift.
    lk(12'h040, 8'h05, 1'b1, 1'b1);
    lk_want(1'b0, 12'h041, 4'h1, "override_lk");
    upd(12'h020, 4'h3, 1'b1, 1'b0, 12'h030);
    tick();
    want(KGhr, 32'h7, "recovered_ghr");
    tick();
    // Not-taken mispredict at idx 5 brings ghr back to 0.
    upd(12'h005, 4'h0, 1'b0, 1'b1, 12'h000);
    tick();
    // Wrap-around with enable low: no shift.
    lk(12'h000, 8'hFE, 1'b0, 1'b1);
    lk_want(1'b1, 12'hFFF, 4'h0, "wrap");
    tick();
    lk(12'h000, 8'hFE, 1'b1, 1'b0);
    lk_want(1'b0, 12'h001, 4'h0, "non_branch");
    tick();
    // Read-before-write on idx 0; taken prediction shifts ghr to 0001.
    lk(12'h000, 8'hFE, 1'b1, 1'b1);
    lk_want(1'b1, 12'hFFF, 4'h0, "rbw");
    upd(12'h000, 4'h0, 1'b0, 1'b0, 12'h000);
    tick();
    lk(12'h001, 8'h05, 1'b0, 1'b1);
    lk_want(1'b0, 12'h002, 4'h1, "after_dec");
    tick();
    upd(12'h010, 4'h0, 1'b1, 1'b0, 12'h100);
    tick();
    // Reset in the flush cycle; a same-cycle mispredict is dropped.
    reset = 1'b1;
    upd(12'h050, 4'h0, 1'b0, 1'b1, 12'h000);
`ifdef PRED_STATS_EN
    want(KStB, 32'd8, "stat_branches");
    want(KStM, 32'd4, "stat_mispredicts");
`endif
    tick();
    reset = 1'b0;
    want(KFdst, 32'h0, "post_rst_flush_dst");
    lk(12'h010, 8'h05, 1'b0, 1'b1);
    lk_want(1'b0, 12'h011, 4'h0, "post_rst_idx0");
`ifdef PRED_STATS_EN
    want(KStB, 32'd0, "stat_branches_rst");
    want(KStM, 32'd0, "stat_mispredicts_rst");
`endif
    tick();
    lk(12'h003, 8'h05, 1'b0, 1'b1);
    lk_want(1'b0, 12'h004, 4'h0, "post_rst_idx3");
    tick();
    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0 || fl_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", exp_q.size(), fl_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
Parametrised successor to the 16-entry bimodal predictor. It is a gshare conditional-branch predictor: a table of CTR_W-bit saturating counters indexed by PC XOR a speculative global history register (GHR). The front end uses it for fetch redirection; the execute stage drives its resolution/update port. It adds GHR checkpoint/recovery and a registered flush/redirect output.

Parameters:
ADDR_W, 12, instruction address width; all address arithmetic wraps modulo 2^ADDR_W
IDX_W, 4, table index width; table depth = 2^IDX_W
GHR_W, 4, global history length; legal range 1..IDX_W, zero-extended to IDX_W before the XOR
CTR_W, 2, saturating counter width, minimum 2

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
enable  in  1  lookup stall gate; 0 freezes speculative GHR advance only
lk_valid  in  1  lookup request this cycle
lk_is_branch  in  1  lookup instruction is a conditional branch
lk_pc  in  ADDR_W  lookup instruction address
lk_offset  in  8  signed branch displacement, sign-extended to ADDR_W
predict_taken  out  1  combinational prediction
predict_dst  out  ADDR_W  combinational next fetch address
lookup_ghr  out  GHR_W  GHR snapshot; the pipeline carries it to resolution
upd_valid  in  1  branch resolved this cycle
upd_pc  in  ADDR_W  resolved branch address
upd_ghr  in  GHR_W  snapshot taken at that branch's lookup
upd_taken  in  1  actual outcome
upd_pred_taken  in  1  prediction made at lookup
upd_target  in  ADDR_W  taken target computed by execute
flush_valid  out  1  registered mispredict redirect
flush_dst  out  ADDR_W  registered redirect address

Behaviour:
- idx(pc, g) = pc[IDX_W-1:0] XOR zero-extend(g).
- Lookup is combinational and reads the counter at idx(lk_pc, ghr_spec).
- predict_taken = lk_valid & lk_is_branch & ctr[msb].
- predict_dst = lk_pc + 1 + sext(lk_offset) if predict_taken, else lk_pc + 1, modulo 2^ADDR_W.
- lookup_ghr = ghr_spec.
- Speculative shift: at the clock edge, if enable & lk_valid & lk_is_branch and there is no mispredict, ghr_spec <= {ghr_spec[GHR_W-2:0], predict_taken}. For GHR_W=1, ghr_spec <= predict_taken.
- Update: when upd_valid, the counter at idx(upd_pc, upd_ghr) increments if upd_taken (saturates at 2^CTR_W-1) or decrements if not (saturates at 0). Updates ignore enable.
- Mispredict = upd_valid & (upd_taken != upd_pred_taken). On a mispredict:
  - ghr_spec <= {upd_ghr[GHR_W-2:0], upd_taken}; recovery overrides any same-cycle speculative shift.
  - The next cycle, flush_valid=1 and flush_dst = upd_taken ? upd_target : upd_pc+1.
- flush_valid is a one-cycle pulse; it is 0 in every cycle not following a mispredict.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update counter (read-before-write).
- Reset, synchronous, applied in one cycle and overriding all same-cycle events:
  - every counter = 2^(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2);
  - ghr_spec = 0, flush_valid = 0, flush_dst = 0.
  - A flush pending at reset is dropped.
- Outputs immediately after reset: predict_taken=0; predict_dst=lk_pc+1; lookup_ghr=0.

Optional Feature:
PRED_STATS_EN: when defined, adds outputs stat_branches[15:0] and stat_mispredicts[15:0].
- stat_branches counts cycles with upd_valid; stat_mispredicts counts mispredicts.
- Both saturate at 0xFFFF, are cleared by reset, and are registered.
- When not defined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
1. After reset: lk_pc=0x010, lk_is_branch=1, lk_offset=0x05 -> predict_taken=0, predict_dst=0x011, lookup_ghr=0.
2. Two updates with upd_pc=0x010, upd_ghr=0, taken=1, pred_taken=1 (no lookups) -> counter[0] goes 01->10->11, flush_valid stays 0. Then lookup pc=0x010, offset=0x05 -> taken, predict_dst=0x016.
3. Continuing from 2: third taken update keeps counter at 11; one not-taken update (pred_taken=1) -> 10. Lookup still predicts taken; the next cycle gives flush_valid=1 and flush_dst=0x011.
4. Update upd_pc=0x020, upd_ghr=0011, taken=1, pred_taken=0, target=0x030, in the same cycle as a branch lookup -> ghr_spec=0111 (shift overridden); next cycle flush_valid=1 and flush_dst=0x030, pulse lasts 1 cycle.
5. Wrap-around: counter at idx 0 taken, ghr_spec=0, lk_pc=0x000, lk_offset=0xFE -> predict_dst=0xFFF. With enable=0, ghr_spec does not shift.
6. Reset asserted in the cycle after a mispredict -> flush_valid=0 and flush_dst=0 next cycle, all counters predict not-taken, and stats are 0 with PRED_STATS_EN defined.
